mii_tx_arbiter: RTL and testbench

- Sequences the MII transmit side feeding the 4B5B/serializer/NRZI transmit path, and shares it between two frame sources.
- Each source supplies a complete MAC frame (destination address through FCS) as a byte stream.
- The block arbitrates round-robin, prepends preamble and SFD, emits nibbles low-first on TX_EN/TXD, and enforces the inter-frame gap.
- Runs entirely in the 25 MHz MII TX_CLK domain.

---
 rtl/mii_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mii_tx_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mii_tx_arbiter.sv
// Round-robin arbiter sharing the MII transmit path between two byte-stream
// frame sources: prepends preamble/SFD, sends nibbles low-first, enforces IFG.
module mii_tx_arbiter #(
    parameter int IFG_NIBBLES = 24,
    parameter int MAX_BYTES   = 1522
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_req0,
    input  logic [7:0] i_data0,
    input  logic       i_last0,
    output logic       o_gnt0,
    output logic       o_rd0,
    input  logic       i_req1,
    input  logic [7:0] i_data1,
    input  logic       i_last1,
    output logic       o_gnt1,
    output logic       o_rd1,
    output logic       o_mii_tx_en,
    output logic [3:0] o_mii_txd,
    output logic       o_busy,
    output logic       o_err
);

    localparam int CNT_W = (IFG_NIBBLES > 16) ? $clog2(IFG_NIBBLES) : 4;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA_LO,
        DATA_HI,
        IFG
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             sel, sel_nx;
    logic             ptr, ptr_nx;
    logic [7:0]       data_q;
    logic             last_q;
    logic             trunc_q;
    logic             final_q;
    logic [10:0]      byte_cnt;

    logic             tx_en_nx;
    logic [3:0]       txd_nx;
    logic             rd_nx;
    logic             err_nx;
    logic [7:0]       src_data;
    logic             src_last;

    assign src_data = sel ? i_data1 : i_data0;
    assign src_last = sel ? i_last1 : i_last0;

    // Next state plus the next value of every registered output.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sel_nx   = sel;
        ptr_nx   = ptr;

        case (state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    sel_nx   = (i_req0 && i_req1) ? ptr : i_req1;
                    state_nx = PRE;
                    cnt_nx   = '0;
                end
            end
            PRE: begin
                if (cnt == CNT_W'(14)) begin
                    state_nx = SFD;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SFD:     state_nx = DATA_LO;
            DATA_LO: state_nx = DATA_HI;
            DATA_HI: begin
                if (final_q) begin
                    state_nx = IFG;
                    cnt_nx   = '0;
                    ptr_nx   = ~sel;
                end else begin
                    state_nx = DATA_LO;
                end
            end
            IFG: begin
                if (cnt == CNT_W'(IFG_NIBBLES - 1)) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        tx_en_nx = (state_nx == PRE) || (state_nx == SFD) ||
                   (state_nx == DATA_LO) || (state_nx == DATA_HI);

        case (state_nx)
            PRE:     txd_nx = 4'h5;
            SFD:     txd_nx = 4'hD;
            DATA_LO: txd_nx = data_q[3:0];
            DATA_HI: txd_nx = data_q[7:4];
            default: txd_nx = 4'h0;
        endcase

        // Byte 0 is fetched in the last preamble cycle; later bytes while the
        // previous byte's low nibble is on the wire.
        rd_nx  = ((state_nx == PRE) && (cnt_nx == CNT_W'(14))) ||
                 ((state_nx == DATA_LO) && !last_q);
        err_nx = (state == DATA_LO) && last_q && trunc_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state       <= IDLE;
            cnt         <= '0;
            sel         <= 1'b0;
            ptr         <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            trunc_q     <= 1'b0;
            final_q     <= 1'b0;
            byte_cnt    <= '0;
            o_mii_tx_en <= 1'b0;
            o_mii_txd   <= 4'h0;
            o_gnt0      <= 1'b0;
            o_gnt1      <= 1'b0;
            o_rd0       <= 1'b0;
            o_rd1       <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            sel         <= sel_nx;
            ptr         <= ptr_nx;
            o_mii_tx_en <= tx_en_nx;
            o_mii_txd   <= txd_nx;
            o_gnt0      <= tx_en_nx & ~sel_nx;
            o_gnt1      <= tx_en_nx & sel_nx;
            o_rd0       <= rd_nx & ~sel_nx;
            o_rd1       <= rd_nx & sel_nx;
            o_busy      <= (state_nx != IDLE);
            o_err       <= err_nx;

            // A byte is latched on every cycle its read strobe is high.
            if (state == IDLE) begin
                byte_cnt <= '0;
            end else if (o_rd0 || o_rd1) begin
                data_q   <= src_data;
                byte_cnt <= byte_cnt + 1'b1;
                if (byte_cnt == 11'(MAX_BYTES - 1)) begin
                    last_q  <= 1'b1;
                    trunc_q <= ~src_last;
                end else begin
                    last_q  <= src_last;
                    trunc_q <= 1'b0;
                end
            end

            if (state == DATA_LO) begin
                final_q <= last_q;
            end
        end
    end

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Bench for mii_tx_arbiter: directed and random frames, every cycle compared
// against a frame-level timing model derived from cycle numbers.
module tb_mii_tx_arbiter;

    localparam int IFG  = 24;
    localparam int MAXB = 4;

    logic       i_clk = 1'b0;
    logic       i_res;
    logic       i_req0, i_last0, i_req1, i_last1;
    logic [7:0] i_data0, i_data1;
    logic       o_gnt0, o_rd0, o_gnt1, o_rd1;
    logic       o_mii_tx_en, o_busy, o_err;
    logic [3:0] o_mii_txd;

    int         assertCount = 0;
    int         failCount   = 0;
    int         ptr         = 0;
    int         frameNo     = 0;
    logic [7:0] frm [2][16];
    int         frmLen [2];
    bit         noLast [2];

    mii_tx_arbiter #(
        .IFG_NIBBLES(IFG),
        .MAX_BYTES  (MAXB)
    ) dut (
        .i_clk      (i_clk),
        .i_res      (i_res),
        .i_req0     (i_req0),
        .i_data0    (i_data0),
        .i_last0    (i_last0),
        .o_gnt0     (o_gnt0),
        .o_rd0      (o_rd0),
        .i_req1     (i_req1),
        .i_data1    (i_data1),
        .i_last1    (i_last1),
        .o_gnt1     (o_gnt1),
        .o_rd1      (o_rd1),
        .o_mii_tx_en(o_mii_tx_en),
        .o_mii_txd  (o_mii_txd),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    always #20 i_clk = ~i_clk;

    // Output vector layout: {tx_en, txd[3:0], gnt0, gnt1, rd0, rd1, busy, err}
    task automatic checkOutput(input string tag, input logic [10:0] expected);
        logic [10:0] observed;
        observed = {o_mii_tx_en, o_mii_txd, o_gnt0, o_gnt1, o_rd0, o_rd1, o_busy, o_err};
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: got %b expected %b (en txd gnt0 gnt1 rd0 rd1 busy err)",
                   tag, observed, expected);
        end
    endtask

    task automatic newFrame(input int s, input int n, input bit nl);
        for (int i = 0; i < 16; i++) frm[s][i] = 8'($urandom);
        frmLen[s] = n;
        noLast[s] = nl;
    endtask

    // A source keeps byte j stable from the cycle after byte j-1 is consumed.
    task automatic driveSources(input int w, input int c);
        int idx;
        for (int s = 0; s < 2; s++) begin
            idx = (s == w && c > 15) ? (c - 14) / 2 : 0;
            if (idx > 15) idx = 15;
            if (s == 0) begin
                i_data0 = frm[0][idx];
                i_last0 = !noLast[0] && (idx == frmLen[0] - 1);
            end else begin
                i_data1 = frm[1][idx];
                i_last1 = !noLast[1] && (idx == frmLen[1] - 1);
            end
        end
    endtask

    // One IDLE decision cycle and, if anything is requested, the whole frame
    // plus IFG. resetAt > 0 asserts reset in that frame cycle and abandons it.
    task automatic applyStimulus(input bit r0, input bit r1, input int resetAt);
        int          w, n, t, k;
        bit          tr, en, rdw;
        logic [3:0]  nib;
        logic [10:0] expected;

        @(negedge i_clk);
        checkOutput($sformatf("idle f%0d", frameNo), 11'b0);
        i_res  = 1'b0;
        i_req0 = r0;
        i_req1 = r1;
        driveSources(-1, 0);
        if (!(r0 || r1)) return;

        w  = (r0 && r1) ? ptr : (r1 ? 1 : 0);
        n  = noLast[w] ? MAXB : ((frmLen[w] < MAXB) ? frmLen[w] : MAXB);
        tr = noLast[w] || (frmLen[w] > MAXB);
        t  = 16 + 2 * n;
        $display("[TB] frame %0d: source %0d, %0d bytes sent, truncated=%0d", frameNo, w, n, tr);

        for (int c = 1; c <= t + IFG; c++) begin
            @(negedge i_clk);
            en = (c <= t);
            if (c <= 15) nib = 4'h5;
            else if (c == 16) nib = 4'hD;
            else if (c <= t) begin
                k   = (c - 17) / 2;
                nib = ((c - 17) % 2 == 0) ? frm[w][k][3:0] : frm[w][k][7:4];
            end else nib = 4'h0;
            rdw = (c == 15) || (c >= 17 && c <= t && (c - 17) % 2 == 0 && (c - 17) / 2 < n - 1);
            expected = {en, nib, en && w == 0, en && w == 1,
                        rdw && w == 0, rdw && w == 1, 1'b1, tr && c == t};
            checkOutput($sformatf("f%0d c%0d", frameNo, c), expected);

            i_req0 = 1'($urandom);
            i_req1 = 1'($urandom);
            driveSources(w, c);
            if (c == resetAt) begin
                i_res = 1'b1;
                ptr   = 0;
                frameNo++;
                return;
            end
        end
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        ptr    = 1 - w;
        frameNo++;
        newFrame(w, $urandom_range(1, 6), $urandom_range(0, 4) == 0);
    endtask

    initial begin
        bit [1:0] r;
        i_res   = 1'b1;
        i_req0  = 1'b0;
        i_req1  = 1'b0;
        i_data0 = 8'h00;
        i_data1 = 8'h00;
        i_last0 = 1'b0;
        i_last1 = 1'b0;
        newFrame(0, 2, 1'b0);
        newFrame(1, 2, 1'b0);

        repeat (2) @(negedge i_clk);
        checkOutput("reset a", 11'b0);
        @(negedge i_clk);
        checkOutput("reset b", 11'b0);

        // Three-byte frame on source 0 only
        frm[0][0] = 8'hA1; frm[0][1] = 8'hB2; frm[0][2] = 8'hC3;
        frmLen[0] = 3; noLast[0] = 1'b0;
        applyStimulus(1'b1, 1'b0, 0);

        // Single-byte frame
        frm[1][0] = 8'h5D; frmLen[1] = 1; noLast[1] = 1'b0;
        applyStimulus(1'b0, 1'b1, 0);

        // Both requesting continuously: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            newFrame(0, 2, 1'b0);
            newFrame(1, 2, 1'b0);
            applyStimulus(1'b1, 1'b1, 0);
        end

        // Pointer at 0 but only source 1 asks, then a shared request goes to 0
        applyStimulus(1'b0, 1'b1, 0);
        newFrame(0, 8, 1'b1);
        applyStimulus(1'b1, 1'b1, 0);

        // Frame exactly MAX bytes long with a proper last flag
        newFrame(1, MAXB, 1'b0);
        applyStimulus(1'b0, 1'b1, 0);

        // Reset in cycle 20 of a frame, then an immediate regrant
        newFrame(1, 4, 1'b0);
        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b1, 1'b1, 0);

        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0);

        for (int i = 0; i < 14; i++) begin
            r = 2'($urandom_range(1, 3));
            applyStimulus(r[0], r[1], 0);
        end

        @(negedge i_clk);
        checkOutput("final idle", 11'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
